// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared types and helpers for the EX-stage forwarding/hazard unit
package fwd_hazard_unit_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W = 32;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } sb_entry_t;
  localparam sb_entry_t SB_EMPTY = '0;
  function automatic logic sb_match(input logic [DEF_REG_ADDR_W-1:0] r, input sb_entry_t x);
    return x.valid & x.regwrite & (x.rd == r) & (r != '0);
  endfunction
  // a load in EX cannot supply data yet, so only a MEM-stage match can cover it
  function automatic fwd_sel_t next_sel(input logic use_r, input logic [DEF_REG_ADDR_W-1:0] r,
                                        input sb_entry_t e, input sb_entry_t m);
    return !use_r ? FWD_RF : (sb_match(r, e) & ~e.memread) ? FWD_MEM : sb_match(r, m) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: decoder-side inputs and forwarding/stall outputs of the hazard unit
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_flush;
  logic                  ext_stall;
  logic                  fwd_a_s1;
  logic                  fwd_a_s0;
  logic                  fwd_b_s1;
  logic                  fwd_b_s0;
  logic                  stall_ifid;
  logic                  bubble_idex;
  logic [CNT_W-1:0]      stall_count;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread,
           ex_flush, ext_stall,
    input  fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall_ifid, bubble_idex, stall_count
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread,
           ex_flush, ext_stall,
    output fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall_ifid, bubble_idex, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit_sb_stage_reg.sv
// fwd_hazard_unit_sb_stage_reg: one scoreboard entry register with hold/clear/load controls
module fwd_hazard_unit_sb_stage_reg
  import fwd_hazard_unit_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      clear,
  input  logic      load,
  input  sb_entry_t d,
  output sb_entry_t q
);
  always_ff @(posedge clk)
    q <= reset ? SB_EMPTY : hold ? q : clear ? SB_EMPTY : load ? d : q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM shadow scoreboard driving registered forwarding selects and load-use stalls
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic reset,
  fwd_hazard_unit_if.slave bus
);
  sb_entry_t             e_q, m_q, id_e;
  fwd_sel_t              a_q, b_q, a_d, b_d;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic [CNT_W-1:0]      cnt_q;
  logic                  lu, stall, kill;
  logic                  unused_m_memread;
  assign unused_m_memread = m_q.memread;
  always_comb begin
    rs1 = bus.id_rs1;
    rs2 = bus.id_rs2;
    id_e = '{valid: bus.id_valid, rd: bus.id_rd, regwrite: bus.id_regwrite, memread: bus.id_memread};
    lu = bus.id_valid & e_q.memread &
         ((bus.id_use_rs1 & sb_match(rs1, e_q)) | (bus.id_use_rs2 & sb_match(rs2, e_q)));
    stall = lu & ~bus.ex_flush & ~bus.ext_stall & ~reset;
    kill = bus.ex_flush | stall;
    a_d = kill ? FWD_RF : next_sel(bus.id_use_rs1, rs1, e_q, m_q);
    b_d = kill ? FWD_RF : next_sel(bus.id_use_rs2, rs2, e_q, m_q);
  end
  fwd_hazard_unit_sb_stage_reg u_e (
    .clk(clk), .reset(reset), .hold(bus.ext_stall), .clear(kill), .load(1'b1), .d(id_e), .q(e_q)
  );
  // the branch or stalled load in EX always advances into MEM
  fwd_hazard_unit_sb_stage_reg u_m (
    .clk(clk), .reset(reset), .hold(bus.ext_stall), .clear(1'b0), .load(1'b1), .d(e_q), .q(m_q)
  );
  always_ff @(posedge clk)
    if (reset) begin
      a_q <= FWD_RF;
      b_q <= FWD_RF;
      cnt_q <= '0;
    end else if (!bus.ext_stall) begin
      a_q <= a_d;
      b_q <= b_d;
      if (stall && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  assign bus.fwd_a_s1 = a_q[1];
  assign bus.fwd_a_s0 = a_q[0];
  assign bus.fwd_b_s1 = b_q[1];
  assign bus.fwd_b_s0 = b_q[0];
  assign bus.stall_ifid = stall;
  assign bus.bubble_idex = stall;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and randomized checks against an in-flight instruction list model
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fwd_hazard_unit_if bus ();
  fwd_hazard_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {bit valid; int rd; bit rw; bit ld;} instr_t;
  instr_t inflight[$];
  instr_t bubble;
  bit [1:0] m_a, m_b;
  logic [31:0] m_cnt;
  int n_checks, n_fail;

  // newest producer wins; a load in EX cannot feed its successor yet
  function automatic bit [1:0] src(input bit use_r, input int r);
    if (!use_r || r == 0) return 2'b00;
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].valid && inflight[i].rw && inflight[i].rd == r) begin
        if (i == 0 && inflight[i].ld) continue;
        return i == 0 ? 2'b10 : 2'b01;
      end
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    instr_t e;
    bit hit;
    e = inflight[0];
    hit = e.valid && e.rw && e.ld &&
          ((bus.id_use_rs1 && bus.id_rs1 != 0 && int'(bus.id_rs1) == e.rd) ||
           (bus.id_use_rs2 && bus.id_rs2 != 0 && int'(bus.id_rs2) == e.rd));
    return !reset && bus.id_valid && hit && !bus.ex_flush && !bus.ext_stall;
  endfunction

  function automatic bit [1:0] obs_a(); return {bus.fwd_a_s1, bus.fwd_a_s0}; endfunction
  function automatic bit [1:0] obs_b(); return {bus.fwd_b_s1, bus.fwd_b_s0}; endfunction

  task automatic tick();
    bit st, rs, es, fl;
    bit [1:0] na, nb;
    instr_t ni;
    st = exp_stall();
    rs = reset; es = bus.ext_stall; fl = bus.ex_flush;
    na = src(bus.id_use_rs1, int'(bus.id_rs1));
    nb = src(bus.id_use_rs2, int'(bus.id_rs2));
    ni = '{bus.id_valid, int'(bus.id_rd), bus.id_regwrite, bus.id_memread};
    @(posedge clk);
    if (rs) begin
      inflight = '{bubble, bubble};
      m_a = 0; m_b = 0; m_cnt = 0;
    end else if (!es) begin
      if (fl || st) begin ni.valid = 0; na = 0; nb = 0; end
      inflight.push_front(ni);
      void'(inflight.pop_back());
      m_a = na; m_b = nb;
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit fl, input bit es);
    bus.id_valid = v; bus.id_rs1 = 5'(rs1); bus.id_use_rs1 = u1;
    bus.id_rs2 = 5'(rs2); bus.id_use_rs2 = u2; bus.id_rd = 5'(rd);
    bus.id_regwrite = rw; bus.id_memread = ld; bus.ex_flush = fl; bus.ext_stall = es;
    #1;
  endtask
  task automatic alu(input int rd, input int rs1, input int rs2, input bit fl = 0, input bit es = 0);
    drive(1, rs1, 1, rs2, 1, rd, 1, 0, fl, es);
  endtask
  task automatic lw(input int rd, input int rs1); drive(1, rs1, 1, 0, 0, rd, 1, 1, 0, 0); endtask
  task automatic nop(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset_pipe(); reset = 1; nop(); tick(); reset = 0; endtask

  task automatic test_reset();
    reset = 1; nop();
    n_checks++; if (bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_ifid); end
    tick(); tick(); reset = 0;
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got a=%b b=%b want 00 00", obs_a(), obs_b()); end
    n_checks++; if (bus.stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.stall_count); end
  endtask

  task automatic test_alu_fwd();
    reset_pipe();
    alu(5, 1, 2); tick();
    alu(6, 5, 1);
    n_checks++; if (bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL alu_nostall: got %b want 0", bus.stall_ifid); end
    tick();
    n_checks++; if (obs_a() !== 2'b10 || obs_b() !== 2'b00) begin n_fail++; $display("FAIL alu_fwd: got a=%b b=%b want 10 00", obs_a(), obs_b()); end
  endtask

  task automatic test_wb_fwd();
    alu(5, 1, 2); tick(); nop(); tick(); alu(7, 2, 5); tick();
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b01) begin n_fail++; $display("FAIL wb_fwd: got a=%b b=%b want 00 01", obs_a(), obs_b()); end
  endtask

  task automatic test_load_use();
    reset_pipe();
    lw(5, 1); tick();
    alu(6, 5, 5);
    n_checks++; if (bus.stall_ifid !== 1'b1 || bus.bubble_idex !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b%b want 11", bus.stall_ifid, bus.bubble_idex); end
    tick();
    n_checks++; if (bus.stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", bus.stall_count); end
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_sel: got a=%b b=%b want 00 00", obs_a(), obs_b()); end
    n_checks++; if (bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL lu_single: got %b want 0", bus.stall_ifid); end
    tick();
    n_checks++; if (obs_a() !== 2'b01 || obs_b() !== 2'b01) begin n_fail++; $display("FAIL lu_fwd: got a=%b b=%b want 01 01", obs_a(), obs_b()); end
  endtask

  task automatic test_x0_and_priority();
    alu(0, 1, 2); tick(); alu(3, 0, 0); tick();
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b00) begin n_fail++; $display("FAIL x0: got a=%b b=%b want 00 00", obs_a(), obs_b()); end
    alu(5, 1, 2); tick(); alu(5, 3, 4); tick(); alu(6, 5, 5); tick();
    n_checks++; if (obs_a() !== 2'b10 || obs_b() !== 2'b10) begin n_fail++; $display("FAIL e_wins: got a=%b b=%b want 10 10", obs_a(), obs_b()); end
  endtask

  task automatic test_flush();
    reset_pipe();
    lw(5, 1); tick();
    alu(6, 5, 5, 1);
    n_checks++; if (bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL flush_nostall: got %b want 0", bus.stall_ifid); end
    tick();
    n_checks++; if (bus.stall_count !== 32'd0 || obs_a() !== 2'b00) begin n_fail++; $display("FAIL flush_state: got cnt=%0d a=%b want 0 00", bus.stall_count, obs_a()); end
    alu(7, 6, 5); tick();
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b01) begin n_fail++; $display("FAIL flush_e_invalid: got a=%b b=%b want 00 01", obs_a(), obs_b()); end
  endtask

  task automatic test_ext_stall();
    reset_pipe();
    lw(5, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 1);
      n_checks++; if (bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL ext_nostall: got %b want 0", bus.stall_ifid); end
      tick();
      n_checks++; if (bus.stall_count !== 32'd0 || obs_a() !== 2'b00 || obs_b() !== 2'b00) begin n_fail++; $display("FAIL ext_frozen: got cnt=%0d a=%b b=%b want 0 00 00", bus.stall_count, obs_a(), obs_b()); end
    end
    alu(6, 5, 5);
    n_checks++; if (bus.stall_ifid !== 1'b1) begin n_fail++; $display("FAIL ext_resume_stall: got %b want 1", bus.stall_ifid); end
    tick(); tick();
    n_checks++; if (bus.stall_count !== 32'd1 || obs_a() !== 2'b01 || obs_b() !== 2'b01) begin n_fail++; $display("FAIL ext_resume: got cnt=%0d a=%b b=%b want 1 01 01", bus.stall_count, obs_a(), obs_b()); end
  endtask

  task automatic test_reset_mid_stall();
    alu(5, 1, 2); tick(); alu(6, 5, 5); tick();
    lw(5, 1); tick(); alu(6, 5, 5);
    n_checks++; if (bus.stall_ifid !== 1'b1) begin n_fail++; $display("FAIL rms_pre: got %b want 1", bus.stall_ifid); end
    reset = 1; #1;
    n_checks++; if (bus.stall_ifid !== 1'b0 || bus.bubble_idex !== 1'b0) begin n_fail++; $display("FAIL rms_reset_cycle: got %b%b want 00", bus.stall_ifid, bus.bubble_idex); end
    tick(); reset = 0; #1;
    n_checks++; if (obs_a() !== 2'b00 || obs_b() !== 2'b00 || bus.stall_count !== 32'd0 || bus.stall_ifid !== 1'b0) begin n_fail++; $display("FAIL rms_after: got a=%b b=%b cnt=%0d st=%b want 00 00 0 0", obs_a(), obs_b(), bus.stall_count, bus.stall_ifid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit ld;
      ld = $urandom_range(3) == 0;
      reset = $urandom_range(49) == 0;
      drive($urandom_range(9) != 0, $urandom_range(7), $urandom_range(3) != 0, $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(7), ld || $urandom_range(4) != 0, ld,
            $urandom_range(9) == 0, $urandom_range(9) == 0);
      n_checks++; if (bus.stall_ifid !== exp_stall() || bus.bubble_idex !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b%b want %b", i, bus.stall_ifid, bus.bubble_idex, exp_stall()); end
      tick();
      n_checks++; if (obs_a() !== m_a || obs_b() !== m_b || bus.stall_count !== m_cnt) begin n_fail++; $display("FAIL rnd_state[%0d]: got a=%b b=%b cnt=%0d want %b %b %0d", i, obs_a(), obs_b(), bus.stall_count, m_a, m_b, m_cnt); end
    end
    reset = 0;
  endtask

  initial begin
    inflight = '{bubble, bubble};
    m_a = 0; m_b = 0; m_cnt = 0;
    test_reset();
    test_alu_fwd();
    test_wb_fwd();
    test_load_use();
    test_x0_and_priority();
    test_flush();
    test_ext_stall();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
